// File: rtl/rv32i_memoryaccess_ctrl_if.sv
// Wishbone-classic data bus between the load/store unit and memory.
// Master drives the cycle, slave answers with ack and read data.
interface rv32i_memoryaccess_ctrl_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we,
    output o_wb_addr, o_wb_sel, o_wb_data,
    input  i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we,
    input  o_wb_addr, o_wb_sel, o_wb_data,
    output i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/rv32i_memoryaccess_ctrl.sv
// RV32I load/store unit: one Wishbone-classic cycle per request,
// aligned and extended loads, misalign / illegal / timeout flags.
module rv32i_memoryaccess_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_data_load,
  output logic        o_load_valid,
  output logic        o_store_done,
  output logic        o_misaligned,
  output logic        o_bus_err,
  rv32i_memoryaccess_ctrl_if.master wb
);

  localparam logic [6:0] OP_LOAD  = 7'b000_0011;
  localparam logic [6:0] OP_STORE = 7'b010_0011;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] load_d;
  logic        lv_d, sd_d, mis_d, err_d;

  logic        is_load, is_store, mem_op;
  logic        illegal, misal;
  logic [31:0] shifted, ext;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign is_load  = (i_opcode == OP_LOAD);
  assign is_store = (i_opcode == OP_STORE);
  assign mem_op   = is_load | is_store;

  always_comb begin
    illegal = 1'b0;
    if (is_store)
      illegal = (i_funct3 > 3'b010);
    else if (is_load)
      illegal = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
    misal = ((i_funct3[1:0] == 2'b01) & i_addr[0])
          | ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
  end

  assign shifted = wb.i_wb_data >> {lo_q, 3'b000};
  assign lb      = shifted[7:0];
  assign lh      = lo_q[1] ? wb.i_wb_data[31:16] : wb.i_wb_data[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{lb[7]}}, lb};
      3'b001:  ext = {{16{lh[15]}}, lh};
      3'b100:  ext = {24'd0, lb};
      3'b101:  ext = {16'd0, lh};
      default: ext = wb.i_wb_data;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    load_d  = o_data_load;
    lv_d    = 1'b0;
    sd_d    = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          unique case (1'b1)
            !mem_op: ;
            mem_op & illegal: err_d = 1'b1;
            mem_op & !illegal & misal: mis_d = 1'b1;
            default: begin
              state_d = BUS;
              cnt_d   = '0;
              we_d    = is_store;
              addr_d  = {i_addr[31:2], 2'b00};
              f3_d    = i_funct3;
              lo_d    = i_addr[1:0];
              sel_d   = 4'b1111;
              data_d  = 32'd0;
              if (is_store) begin
                case (i_funct3[1:0])
                  2'b00: begin
                    sel_d  = 4'b0001 << i_addr[1:0];
                    data_d = {4{i_rs2[7:0]}};
                  end
                  2'b01: begin
                    sel_d  = i_addr[1] ? 4'b1100 : 4'b0011;
                    data_d = {2{i_rs2[15:0]}};
                  end
                  default: data_d = i_rs2;
                endcase
              end
            end
          endcase
        end
      end
      BUS: begin
        if (wb.i_wb_ack) begin
          state_d = IDLE;
          if (we_q) begin
            sd_d = 1'b1;
          end else begin
            lv_d   = 1'b1;
            load_d = ext;
          end
        end else if (cnt == LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      sel_q        <= 4'd0;
      data_q       <= 32'd0;
      f3_q         <= 3'd0;
      lo_q         <= 2'd0;
      o_data_load  <= 32'd0;
      o_load_valid <= 1'b0;
      o_store_done <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
      o_data_load  <= load_d;
      o_load_valid <= lv_d;
      o_store_done <= sd_d;
      o_misaligned <= mis_d;
      o_bus_err    <= err_d;
    end
  end

  assign o_ready      = (state == IDLE);
  assign wb.o_wb_cyc  = (state == BUS);
  assign wb.o_wb_stb  = (state == BUS);
  assign wb.o_wb_we   = (state == BUS) & we_q;
  assign wb.o_wb_addr = addr_q;
  assign wb.o_wb_sel  = sel_q;
  assign wb.o_wb_data = data_q;

endmodule
